// File: rtl/ws2812b_rx_decoder.sv
// WS2812B serial stream decoder: recovers GRB pixels and frame-latch events from leds_line.
// Optional frame checksum output enabled by defining WS2812B_RX_FRAME_SUM_EN.
module ws2812b_rx_decoder #(
  parameter int MAX_POS       = 109,
  parameter int BIT1_MIN_CLK  = 30,
  parameter int MIN_HIGH_CLK  = 8,
  parameter int MAX_HIGH_CLK  = 60,
  parameter int RESET_CLK_CNT = 2500
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       leds_line,
  output logic                       pixel_valid,
  output logic [$clog2(MAX_POS)-1:0] pixel_index,
  output logic [7:0]                 pixel_green,
  output logic [7:0]                 pixel_red,
  output logic [7:0]                 pixel_blue,
  output logic                       frame_done,
  output logic [$clog2(MAX_POS):0]   frame_pixel_count,
  output logic                       frame_error
`ifdef WS2812B_RX_FRAME_SUM_EN
  ,
  output logic [15:0]                frame_sum
`endif
);

  localparam int IDX_W = $clog2(MAX_POS);
  localparam int CNT_W = $clog2(RESET_CLK_CNT + 1);
  localparam logic [CNT_W-1:0] LOW_LAST  = CNT_W'(RESET_CLK_CNT - 1);
  localparam logic [CNT_W-1:0] HIGH_LAST = CNT_W'(MAX_HIGH_CLK - 1);
  localparam logic [CNT_W-1:0] MIN_HIGH  = CNT_W'(MIN_HIGH_CLK);
  localparam logic [CNT_W-1:0] BIT1_LIM  = CNT_W'(BIT1_MIN_CLK);
  localparam logic [IDX_W:0]   POS_LIMIT = (IDX_W + 1)'(MAX_POS);

  typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} state_t;

  state_t           state_q, state_d;
  logic             sync1, ls;
  logic [CNT_W-1:0] low_cnt, high_cnt;
  logic [4:0]       bit_cnt;
  logic [IDX_W:0]   pix_cnt;
  logic [23:0]      shift_reg;
  logic             err_flag, any_bit, pix_pend;

  logic do_shift, bad_pulse, too_long, do_latch, sync_done;
  logic high_clr, high_inc, low_clr, low_inc;
  logic new_bit, pixel_accept, frame_clr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      ls    <= 1'b0;
    end else begin
      sync1 <= leds_line;
      ls    <= sync1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= SYNC;
    else        state_q <= state_d;
  end

  // Every state observes the synchronised level directly; the state itself tells us which edge a change means.
  always_comb begin
    state_d   = state_q;
    do_shift  = 1'b0;
    bad_pulse = 1'b0;
    too_long  = 1'b0;
    do_latch  = 1'b0;
    sync_done = 1'b0;
    high_clr  = 1'b0;
    high_inc  = 1'b0;
    low_clr   = 1'b0;
    low_inc   = 1'b0;
    unique case (state_q)
      SYNC: begin
        if (ls) low_clr = 1'b1;
        else if (low_cnt == LOW_LAST) begin
          sync_done = 1'b1;
          state_d   = IDLE;
        end else low_inc = 1'b1;
      end
      IDLE: begin
        if (ls) begin
          high_clr = 1'b1;
          state_d  = HIGH;
        end
      end
      HIGH: begin
        if (ls) begin
          if (high_cnt == HIGH_LAST) begin
            too_long = 1'b1;
            low_clr  = 1'b1;
            state_d  = SYNC;
          end else high_inc = 1'b1;
        end else begin
          low_clr = 1'b1;
          state_d = LOW;
          if (high_cnt < MIN_HIGH) bad_pulse = 1'b1;
          else                     do_shift  = 1'b1;
        end
      end
      LOW: begin
        if (ls) begin
          high_clr = 1'b1;
          state_d  = HIGH;
        end else if (low_cnt == LOW_LAST) begin
          do_latch = 1'b1;
          state_d  = IDLE;
        end else low_inc = 1'b1;
      end
      default: state_d = SYNC;
    endcase
  end

  assign new_bit      = (high_cnt >= BIT1_LIM);
  assign pixel_accept = pix_pend && (pix_cnt < POS_LIMIT);
  assign frame_clr    = do_latch || sync_done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      low_cnt  <= '0;
      high_cnt <= '0;
    end else begin
      if (low_clr)       low_cnt <= '0;
      else if (low_inc)  low_cnt <= low_cnt + 1'b1;
      if (high_clr)      high_cnt <= '0;
      else if (high_inc) high_cnt <= high_cnt + 1'b1;
    end
  end

  // Leaving SYNC also clears frame state so a frame broken by an over-long pulse is discarded.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_reg         <= '0;
      bit_cnt           <= '0;
      pix_cnt           <= '0;
      err_flag          <= 1'b0;
      any_bit           <= 1'b0;
      pix_pend          <= 1'b0;
      pixel_valid       <= 1'b0;
      pixel_index       <= '0;
      pixel_green       <= '0;
      pixel_red         <= '0;
      pixel_blue        <= '0;
      frame_done        <= 1'b0;
      frame_pixel_count <= '0;
      frame_error       <= 1'b0;
    end else begin
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      pix_pend    <= do_shift && (bit_cnt == 5'd23);
      if (do_shift) begin
        shift_reg <= {shift_reg[22:0], new_bit};
        any_bit   <= 1'b1;
        bit_cnt   <= (bit_cnt == 5'd23) ? 5'd0 : bit_cnt + 5'd1;
      end
      if (pixel_accept) begin
        pixel_valid <= 1'b1;
        pixel_index <= pix_cnt[IDX_W-1:0];
        pixel_green <= shift_reg[23:16];
        pixel_red   <= shift_reg[15:8];
        pixel_blue  <= shift_reg[7:0];
        pix_cnt     <= pix_cnt + 1'b1;
      end
      if (bad_pulse || too_long || (pix_pend && !pixel_accept)) err_flag <= 1'b1;
      if (do_latch && any_bit) begin
        frame_done        <= 1'b1;
        frame_pixel_count <= pix_cnt;
        frame_error       <= err_flag || (bit_cnt != 5'd0);
      end
      if (frame_clr) begin
        bit_cnt  <= '0;
        pix_cnt  <= '0;
        err_flag <= 1'b0;
        any_bit  <= 1'b0;
      end
    end
  end

`ifdef WS2812B_RX_FRAME_SUM_EN
  logic [15:0] sum_acc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_acc   <= '0;
      frame_sum <= '0;
    end else begin
      if (frame_clr) sum_acc <= '0;
      else if (pixel_accept)
        sum_acc <= sum_acc + 16'(shift_reg[23:16]) + 16'(shift_reg[15:8]) + 16'(shift_reg[7:0]);
      if (do_latch && any_bit) frame_sum <= sum_acc;
    end
  end
`endif

endmodule
